mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It takes rs/rt operands straight from the register file read ports (readdata1/readdata2). It executes mult, multu, div and divu over multiple cycles, and returns HI or LO on `result` for mfhi/mflo, which the writeback mux routes to the register file `writedata`. The control unit stalls the PC while `busy` is high.

## Interface
- No parameters; all datapaths fixed at 32 bits.
- `clk`  in  1  system clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  launch op; sampled only in IDLE
- `op`  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with `start`
- `srca`  in  32  rs value: multiplicand / dividend; also mthi/mtlo data
- `srcb`  in  32  rt value: multiplier / divisor
- `mtwrite`  in  1  mthi/mtlo write strobe; honoured only in IDLE
- `mtsel`  in  1  1 = write HI, 0 = write LO (for `mtwrite`)
- `hisel`  in  1  1 = `result` shows HI, 0 = LO
- `result`  out  32  combinational `hisel ? HI : LO`
- `busy`  out  1  high while an op is in flight
- `done`  out  1  one-cycle pulse when HI/LO have just been updated

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - `start`=1 latches op, srca and srcb, clears the 5-bit iteration counter, and goes to CALC.
  - Signed ops (mult, div) latch operand magnitudes plus sign flags; unsigned ops latch raw operands.
- CALC runs one iteration per cycle, 32 iterations (counter 0..31), then goes to FIX.
  - Multiply: shift-add on a 64-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division on 32-bit remainder/quotient registers, one quotient bit per cycle, MSB first.
- FIX (1 cycle) applies sign correction, writes HI/LO, pulses `done`, and returns to IDLE.
  - mult: 64-bit product negated if the operand signs differ. HI = product[63:32], LO = product[31:0].
  - div: quotient negated if the operand signs differ; remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0 (magnitude wrap, no trap).
  - Divide by zero (div or divu): LO=0xFFFFFFFF, HI=original srca. No exception; normal latency.
- `mtwrite` in IDLE with `start`=0: HI or LO ← srca on that edge. If `start` and `mtwrite` are both high, `start` wins and `mtwrite` is dropped.
- `start` and `mtwrite` are ignored in CALC and FIX. HI/LO are written only by FIX, `mtwrite` or `rst`.
- Reset (at any time, including mid-op): state IDLE, HI=LO=0, counter=0, `busy`=0, `done`=0, so `result`=0. A partially computed result is discarded.

## Timing
- Let E0 be the edge sampling `start`=1 in IDLE.
- `busy`=1 from after E0 through the cycle ending at E33.
  - E1..E32 are the CALC iterations.
  - E33 is the FIX edge, which writes HI/LO.
- After E33: `busy`=0, `done`=1 for exactly one cycle, and `result` shows the new HI/LO.
- Total latency: 33 cycles from the start edge to HI/LO valid.
- A new `start` is accepted on E34 at the earliest (the cycle where `done`=1); back-to-back ops are legal.
- While `busy`=1, `result` shows the old HI/LO; consumers must not read it.
- `mtwrite` latency is one edge; `result` reflects the new value immediately after that edge.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF -> `done` 33 cycles after the start edge; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for exactly 33 cycles.
- mult 0xFFFFFFFD (−3) × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then div −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 100 / 0 -> LO=0xFFFFFFFF, HI=0x00000064. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- mtwrite HI←0x12345678, then a start issued mid-op with mtwrite LO←0xDEAD -> both ignored while busy; final HI/LO equal the op's product only.
- `start` and `mtwrite` in the same IDLE cycle -> op runs, HI/LO untouched until FIX; mthi value never appears.
- `rst` pulse asynchronously at iteration 15 -> `busy`, `done` and `result` go to 0 immediately. A following divu 9/4 -> LO=2, HI=1 at normal latency.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32x32 multiply / 32/32 divide with architectural
// HI/LO registers. One iteration per cycle, 32 iterations, then one fix-up
// cycle that applies sign correction and commits HI/LO.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        mtwrite,
    input  logic        mtsel,
    input  logic        hisel,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_next;

    // Architectural registers
    logic [31:0] hi, lo;

    // In-flight operation context
    logic        isdiv;
    logic [4:0]  count;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [63:0] acc;
    logic        nega, negb, divzero;

    // Operand magnitudes for signed ops; raw operands for unsigned ops
    logic        issigned;
    logic [31:0] maga, magb;

    assign issigned = ~op[0];
    assign maga     = (issigned && srca[31]) ? -srca : srca;
    assign magb     = (issigned && srcb[31]) ? -srcb : srcb;

    // Multiply step: add the shifted multiplicand when the current
    // multiplier bit (always at opb[0], since opb shifts right) is set
    logic [63:0] addend;
    assign addend = opb[0] ? ({32'b0, opa} << count) : 64'b0;

    // Restoring divide step: acc[63:32] is the partial remainder, acc[31:0]
    // holds the dividend bits still to be consumed, with quotient bits
    // entering from the bottom
    logic [32:0] shifted, diff;
    assign shifted = {acc[63:32], acc[31]};
    assign diff    = shifted - {1'b0, opb};

    // Sign-corrected results committed in FIX; divide-by-zero forces an
    // all-ones quotient while the remainder path reproduces the dividend
    logic [63:0] prod;
    logic [31:0] quo, rem;
    assign prod = (nega ^ negb) ? -acc : acc;
    assign quo  = divzero ? 32'hFFFF_FFFF
                          : ((nega ^ negb) ? -acc[31:0] : acc[31:0]);
    assign rem  = nega ? -acc[63:32] : acc[63:32];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and combinational outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        result     = hisel ? hi : lo;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, HI/LO commit and mthi/mtlo writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi      <= 32'b0;
            lo      <= 32'b0;
            isdiv   <= 1'b0;
            count   <= 5'b0;
            opa     <= 32'b0;
            opb     <= 32'b0;
            acc     <= 64'b0;
            nega    <= 1'b0;
            negb    <= 1'b0;
            divzero <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        isdiv   <= op[1];
                        count   <= 5'b0;
                        nega    <= issigned & srca[31];
                        negb    <= issigned & srcb[31];
                        divzero <= (srcb == 32'd0);
                        opa     <= maga;
                        opb     <= magb;
                        if (op[1]) begin
                            acc <= {32'b0, maga};
                        end else begin
                            acc <= 64'b0;
                        end
                    end else if (mtwrite) begin
                        if (mtsel) begin
                            hi <= srca;
                        end else begin
                            lo <= srca;
                        end
                    end
                end
                CALC: begin
                    count <= count + 5'd1;
                    if (isdiv) begin
                        if (!diff[32]) begin
                            acc <= {diff[31:0], acc[30:0], 1'b1};
                        end else begin
                            acc <= {shifted[31:0], acc[30:0], 1'b0};
                        end
                    end else begin
                        acc <= acc + addend;
                        opb <= {1'b0, opb[31:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (isdiv) begin
                        hi <= rem;
                        lo <= quo;
                    end else begin
                        hi <= prod[63:32];
                        lo <= prod[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        mtwrite;
    logic        mtsel;
    logic        hisel;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int ncyc;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mul_div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .srca    (srca),
        .srcb    (srcb),
        .mtwrite (mtwrite),
        .mtsel   (mtsel),
        .hisel   (hisel),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    // Free-running clock, 10 time-unit period
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic mw, input logic ms);
        start   = s;
        op      = o;
        srca    = a;
        srcb    = b;
        mtwrite = mw;
        mtsel   = ms;
    endtask

    // Called at a negedge; drives start across one posedge then releases
    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        applyStimulus(1'b1, o, a, b, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Samples at negedges until done, counting busy cycles, with a bound
    task automatic waitDone(input string tag, output int n);
        int guard;
        n = 0;
        guard = 0;
        while (done !== 1'b1 && guard < 100) begin
            if (busy === 1'b1) n++;
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, " done_seen"}, {31'b0, done}, 32'd1);
    endtask

    task automatic checkRegs(input string tag, input logic [31:0] exphi,
                             input logic [31:0] explo);
        hisel = 1'b1;
        #1;
        checkOutput({tag, " hi"}, result, exphi);
        hisel = 1'b0;
        #1;
        checkOutput({tag, " lo"}, result, explo);
    endtask

    initial begin
        rst = 1'b1;
        hisel = 1'b0;
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkRegs("reset", 32'h0, 32'h0);

        // multu max x max with latency and done-width checks
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDone("multu", ncyc);
        checkOutput("multu busy_cycles", ncyc, 32'd33);
        checkOutput("multu busy_at_done", {31'b0, busy}, 32'd0);
        checkRegs("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        checkOutput("multu done_pulse_width", {31'b0, done}, 32'd0);

        // Signed multiply and divide
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        waitDone("mult", ncyc);
        checkRegs("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        waitDone("div", ncyc);
        checkOutput("div busy_cycles", ncyc, 32'd33);
        checkRegs("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Divide by zero and the signed overflow case
        launch(OP_DIVU, 32'd100, 32'd0);
        waitDone("divu0", ncyc);
        checkOutput("divu0 busy_cycles", ncyc, 32'd33);
        checkRegs("divu0", 32'h0000_0064, 32'hFFFF_FFFF);
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        waitDone("divovf", ncyc);
        checkRegs("divovf", 32'h0000_0000, 32'h8000_0000);

        // mthi, then start/mtlo attempts while busy must be ignored
        applyStimulus(1'b0, 2'b00, 32'h1234_5678, 32'd0, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        checkRegs("mthi", 32'h1234_5678, 32'h8000_0000);
        launch(OP_MULTU, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        applyStimulus(1'b1, OP_DIVU, 32'h0000_DEAD, 32'd1, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        checkRegs("busy_hold", 32'h1234_5678, 32'h8000_0000);
        waitDone("busy_ignore", ncyc);
        checkRegs("busy_ignore", 32'h0000_0000, 32'h0000_000F);

        // start and mtwrite together: start wins, mthi value never lands
        applyStimulus(1'b1, OP_MULTU, 32'd6, 32'd7, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
        checkRegs("start_wins_early", 32'h0000_0000, 32'h0000_000F);
        waitDone("start_wins", ncyc);
        checkOutput("start_wins busy_cycles", ncyc, 32'd33);
        checkRegs("start_wins", 32'h0000_0000, 32'h0000_002A);

        // Asynchronous reset mid-op, then a normal divu
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (15) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midreset busy", {31'b0, busy}, 32'd0);
        checkOutput("midreset done", {31'b0, done}, 32'd0);
        checkRegs("midreset", 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(OP_DIVU, 32'd9, 32'd4);
        waitDone("divu94", ncyc);
        checkOutput("divu94 busy_cycles", ncyc, 32'd33);
        checkRegs("divu94", 32'h0000_0001, 32'h0000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
